// File: rtl/filter_pkg.sv
// Shared constants for the sharpening filter: kernel mode codes, pipeline depth
// and the accumulator width helper.
package filter_pkg;

    localparam logic [1:0] MODE_BYPASS = 2'd0;
    localparam logic [1:0] MODE_CROSS  = 2'd1;
    localparam logic [1:0] MODE_FULL   = 2'd2;

    localparam int PIPE_LAT = 5;

    // Wide enough for lap (WIDTH+5) times the zero-extended gain (GAIN_W+1).
    function automatic int acc_w(input int width, input int gain_w);
        return width + gain_w + 6;
    endfunction

endpackage

// File: rtl/filter_core.sv
// 3x3 window generator: two line buffers that advance only on valid pixels.
// Syncs are delayed one clock to line up with the registered window.
module filter_core #(
    parameter int WIDTH  = 8,
    parameter int LINE_W = 640
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_bypass,
    input  logic [WIDTH-1:0]      i_d,
    input  logic                  i_dv,
    input  logic                  i_hs,
    input  logic                  i_vs,
    output logic [8:0][WIDTH-1:0] o_win,
    output logic [WIDTH-1:0]      o_c,
    output logic                  o_dv,
    output logic                  o_hs,
    output logic                  o_vs
);

    logic [LINE_W-1:0][WIDTH-1:0] r_lb1;
    logic [LINE_W-1:0][WIDTH-1:0] r_lb2;
    logic [8:0][WIDTH-1:0]        r_win;
    logic                         r_dv;
    logic                         r_hs;
    logic                         r_vs;

    // r_win index 0..8 = p1..p9, row-major; index 8 is the newest pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lb1 <= '0;
            r_lb2 <= '0;
            r_win <= '0;
            r_dv  <= 1'b0;
            r_hs  <= 1'b0;
            r_vs  <= 1'b0;
        end else begin
            r_dv <= i_dv;
            r_hs <= i_hs;
            r_vs <= i_vs;
            if (i_dv) begin
                r_lb1 <= {r_lb1[LINE_W-2:0], i_d};
                r_lb2 <= {r_lb2[LINE_W-2:0], r_lb1[LINE_W-1]};
                r_win <= {i_d, r_win[8], r_win[7],
                          r_lb1[LINE_W-1], r_win[5], r_win[4],
                          r_lb2[LINE_W-1], r_win[2], r_win[1]};
            end
        end
    end

    assign o_win = r_win;
    assign o_c   = i_bypass ? r_win[8] : r_win[4];
    assign o_dv  = r_dv;
    assign o_hs  = r_hs;
    assign o_vs  = r_vs;

endmodule

// File: rtl/filter_sharpening_ext.sv
// 3x3 Laplacian sharpener with per-frame mode/strength, 5-clock pipeline after
// the window generator, clamped output and matched-latency sync passthrough.
module filter_sharpening_ext
    import filter_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int GAIN_W = 4,
    parameter int LINE_W = 640
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bypass,
    input  logic [1:0]        mode,
    input  logic [GAIN_W-1:0] strength,
    input  logic [WIDTH-1:0]  d_in,
    input  logic              dv_in,
    input  logic              hs_in,
    input  logic              vs_in,
    output logic [WIDTH-1:0]  dout,
    output logic              dv_out,
    output logic              hs_out,
    output logic              vs_out
);

    localparam int ACC_W = acc_w(WIDTH, GAIN_W);
    localparam int LAP_W = WIDTH + 5;
    localparam int RES_W = ACC_W + 1;
    localparam int SUM_W = WIDTH + 2;
    localparam logic signed [RES_W-1:0] MAX_PIX = RES_W'((1 << WIDTH) - 1);

    logic [8:0][WIDTH-1:0] w_win;
    logic [WIDTH-1:0]      w_c;
    logic                  w_dv, w_hs, w_vs;

    filter_core #(.WIDTH(WIDTH), .LINE_W(LINE_W)) u_core (
        .clk      (clk),
        .rst      (rst),
        .i_bypass (bypass),
        .i_d      (d_in),
        .i_dv     (dv_in),
        .i_hs     (hs_in),
        .i_vs     (vs_in),
        .o_win    (w_win),
        .o_c      (w_c),
        .o_dv     (w_dv),
        .o_hs     (w_hs),
        .o_vs     (w_vs)
    );

    logic [1:0]        r_mode_q;
    logic [GAIN_W-1:0] r_k_q;
    logic              r_vs_prev;
    logic              r_armed;
    logic              w_vs_rise;

    // After reset the core reports vs low even if the frame is still active, so a
    // rise only counts once a genuine low (core and input both low) has been seen.
    assign w_vs_rise = w_vs & ~r_vs_prev & r_armed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode_q  <= MODE_BYPASS;
            r_k_q     <= '0;
            r_vs_prev <= 1'b0;
            r_armed   <= 1'b0;
        end else begin
            r_vs_prev <= w_vs;
            r_armed   <= r_armed | (~w_vs & ~vs_in);
            if (w_vs_rise) begin
                r_mode_q <= mode;
                r_k_q    <= strength;
            end
        end
    end

    logic [SUM_W-1:0]  w_sc, w_sd;
    logic [SUM_W-1:0]  r_sc, r_sd;
    logic [WIDTH-1:0]  r_r5, r_rc;
    logic [1:0]        r_m;
    logic [GAIN_W-1:0] r_g;

    assign w_sc = SUM_W'(w_win[1]) + SUM_W'(w_win[3]) + SUM_W'(w_win[5]) + SUM_W'(w_win[7]);
    assign w_sd = SUM_W'(w_win[0]) + SUM_W'(w_win[2]) + SUM_W'(w_win[6]) + SUM_W'(w_win[8]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sc <= '0;
            r_sd <= '0;
            r_r5 <= '0;
            r_rc <= '0;
            r_m  <= MODE_BYPASS;
            r_g  <= '0;
        end else if (w_dv) begin
            r_sc <= w_sc;
            r_sd <= w_sd;
            r_r5 <= w_win[4];
            r_rc <= w_c;
            r_m  <= r_mode_q;
            r_g  <= r_k_q;
        end
    end

    logic signed [LAP_W-1:0] w_r5e, w_sce, w_sde, w_lap, r_lap;
    logic signed [ACC_W-1:0] w_prod, r_prod;
    logic signed [RES_W-1:0] w_res, r_res;
    logic [WIDTH-1:0]        r_r5_1, r_r5_2, r_rc_1, r_rc_2, r_rc_3;
    logic [1:0]              r_m_1, r_m_2, r_m_3;
    logic [GAIN_W-1:0]       r_g_1;
    logic [WIDTH-1:0]        w_clamp, r_dout;
    logic                    w_byp;

    assign w_r5e  = $signed(LAP_W'(r_r5));
    assign w_sce  = $signed(LAP_W'(r_sc));
    assign w_sde  = $signed(LAP_W'(r_sd));
    assign w_lap  = (r_m == MODE_CROSS) ? (w_r5e <<< 2) - w_sce
                                        : (w_r5e <<< 3) - w_sce - w_sde;
    assign w_prod = ACC_W'(r_lap) * ACC_W'($signed({1'b0, r_g_1}));
    assign w_res  = RES_W'(r_prod >>> 2) + $signed(RES_W'(r_r5_2));
    assign w_byp  = (r_m_3 != MODE_CROSS) && (r_m_3 != MODE_FULL);

    always_comb begin
        w_clamp = r_res[WIDTH-1:0];
        if (r_res[RES_W-1]) begin
            w_clamp = '0;
        end else if (r_res > MAX_PIX) begin
            w_clamp = '1;
        end
    end

    logic [PIPE_LAT-1:0] r_dv_sr, r_hs_sr, r_vs_sr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lap   <= '0;
            r_prod  <= '0;
            r_res   <= '0;
            r_r5_1  <= '0;
            r_r5_2  <= '0;
            r_rc_1  <= '0;
            r_rc_2  <= '0;
            r_rc_3  <= '0;
            r_m_1   <= MODE_BYPASS;
            r_m_2   <= MODE_BYPASS;
            r_m_3   <= MODE_BYPASS;
            r_g_1   <= '0;
            r_dout  <= '0;
            r_dv_sr <= '0;
            r_hs_sr <= '0;
            r_vs_sr <= '0;
        end else begin
            r_lap   <= w_lap;
            r_r5_1  <= r_r5;
            r_rc_1  <= r_rc;
            r_m_1   <= r_m;
            r_g_1   <= r_g;
            r_prod  <= w_prod;
            r_r5_2  <= r_r5_1;
            r_rc_2  <= r_rc_1;
            r_m_2   <= r_m_1;
            r_res   <= w_res;
            r_rc_3  <= r_rc_2;
            r_m_3   <= r_m_2;
            r_dv_sr <= {r_dv_sr[PIPE_LAT-2:0], w_dv};
            r_hs_sr <= {r_hs_sr[PIPE_LAT-2:0], w_hs};
            r_vs_sr <= {r_vs_sr[PIPE_LAT-2:0], w_vs};
            if (!r_dv_sr[PIPE_LAT-2]) begin
                r_dout <= '0;
            end else begin
                r_dout <= w_byp ? r_rc_3 : w_clamp;
            end
        end
    end

    assign dout   = r_dout;
    assign dv_out = r_dv_sr[PIPE_LAT-1];
    assign hs_out = r_hs_sr[PIPE_LAT-1];
    assign vs_out = r_vs_sr[PIPE_LAT-1];

endmodule

// File: tb/tb_filter_sharpening_ext.sv
// Scoreboard bench: stimulus pushes expected pixels from a window/kernel model,
// per-DUT monitors pop and compare on dv_out and check sync delay every cycle.
module tb_filter_sharpening_ext;

    localparam int L    = 8;
    localparam int ROWS = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       a_bypass = 1'b0, a_dv = 1'b0, a_hs = 1'b0, a_vs = 1'b0;
    logic [1:0] a_mode = 2'd0;
    logic [3:0] a_k = 4'd0;
    logic [7:0] a_d = 8'd0;
    logic [7:0] a_dout;
    logic       a_dv_out, a_hs_out, a_vs_out;

    logic       b_bypass = 1'b0, b_dv = 1'b0, b_hs = 1'b0, b_vs = 1'b0;
    logic [1:0] b_mode = 2'd0;
    logic [5:0] b_k = 6'd0;
    logic [9:0] b_d = 10'd0;
    logic [9:0] b_dout;
    logic       b_dv_out, b_hs_out, b_vs_out;

    filter_sharpening_ext #(.WIDTH(8), .GAIN_W(4), .LINE_W(L)) dut_a (
        .clk(clk), .rst(rst), .bypass(a_bypass), .mode(a_mode), .strength(a_k),
        .d_in(a_d), .dv_in(a_dv), .hs_in(a_hs), .vs_in(a_vs),
        .dout(a_dout), .dv_out(a_dv_out), .hs_out(a_hs_out), .vs_out(a_vs_out));

    filter_sharpening_ext #(.WIDTH(10), .GAIN_W(6), .LINE_W(L)) dut_b (
        .clk(clk), .rst(rst), .bypass(b_bypass), .mode(b_mode), .strength(b_k),
        .d_in(b_d), .dv_in(b_dv), .hs_in(b_hs), .vs_in(b_vs),
        .dout(b_dout), .dv_out(b_dv_out), .hs_out(b_hs_out), .vs_out(b_vs_out));

    int checks = 0;
    int errors = 0;

    int ha[$], hb[$];
    int qa[$], qb[$];
    int cfg_m[2], cfg_k[2], prev_vs[2], armed[2];
    logic [2:0] sh_a [6];
    logic [2:0] sh_b [6];
    int img [ROWS][L];

    task automatic chk(input string nm, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, want);
        end
    endtask

    function automatic int gh(input int h[$], input int i);
        return (i >= 0) ? h[i] : 0;
    endfunction

    // Window of the newest pixel: bottom row = last 3 pixels, middle row one line
    // back, top row two lines back; unwritten line-buffer slots read as 0.
    function automatic int ref_out(input int h[$], input int m, input int k,
                                   input int bp, input int w);
        int n = h.size() - 1;
        int p[9];
        int c, sc, sd, lap, prod, res, mx;
        p[0] = gh(h, n-2*L-2); p[1] = gh(h, n-2*L-1); p[2] = gh(h, n-2*L);
        p[3] = gh(h, n-L-2);   p[4] = gh(h, n-L-1);   p[5] = gh(h, n-L);
        p[6] = gh(h, n-2);     p[7] = gh(h, n-1);     p[8] = gh(h, n);
        c = (bp != 0) ? p[8] : p[4];
        if (m != 1 && m != 2) return c;
        sc   = p[1] + p[3] + p[5] + p[7];
        sd   = p[0] + p[2] + p[6] + p[8];
        lap  = (m == 1) ? 4*p[4] - sc : 8*p[4] - sc - sd;
        prod = lap * k;
        res  = p[4] + (prod >>> 2);
        mx   = (1 << w) - 1;
        if (res < 0) return 0;
        if (res > mx) return mx;
        return res;
    endfunction

    task automatic drive(input int sel, input bit dv, input bit hs, input bit vs, input int pix);
        int o = 1 - sel;
        if (sel == 0) begin
            a_d = 8'(pix); a_dv = dv; a_hs = hs; a_vs = vs;
        end else begin
            b_d = 10'(pix); b_dv = dv; b_hs = hs; b_vs = vs;
        end
        if (prev_vs[o] == 0) armed[o] = 1;
        prev_vs[o] = 0;
        if (!vs && prev_vs[sel] == 0) armed[sel] = 1;
        if (vs && prev_vs[sel] == 0 && armed[sel] != 0) begin
            cfg_m[sel] = (sel == 0) ? int'(a_mode) : int'(b_mode);
            cfg_k[sel] = (sel == 0) ? int'(a_k) : int'(b_k);
        end
        prev_vs[sel] = vs ? 1 : 0;
        if (dv) begin
            if (sel == 0) begin
                ha.push_back(pix);
                qa.push_back(ref_out(ha, cfg_m[0], cfg_k[0], int'(a_bypass), 8));
            end else begin
                hb.push_back(pix);
                qb.push_back(ref_out(hb, cfg_m[1], cfg_k[1], int'(b_bypass), 10));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic mid_reset();
        rst = 1'b1;
        #1;
        chk("rst_dout", int'(a_dout), 0);
        chk("rst_dv_out", int'(a_dv_out), 0);
        chk("rst_hs_out", int'(a_hs_out), 0);
        chk("rst_vs_out", int'(a_vs_out), 0);
        ha.delete(); hb.delete(); qa.delete(); qb.delete();
        for (int i = 0; i < 6; i++) begin
            sh_a[i] = 3'b000;
            sh_b[i] = 3'b000;
        end
        for (int s = 0; s < 2; s++) begin
            cfg_m[s] = 0; cfg_k[s] = 0; prev_vs[s] = 1; armed[s] = 0;
        end
        rst = 1'b0;
        #1;
    endtask

    task automatic send_frame(input int sel, input int sw_row, input int rst_pix);
        drive(sel, 0, 0, 1, 0);
        drive(sel, 0, 0, 1, 0);
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < L; c++) begin
                if (r == sw_row && c == 0) a_mode = 2'd0;
                if (r*L + c == rst_pix) mid_reset();
                drive(sel, 1, 1, 1, img[r][c]);
            end
            drive(sel, 0, 0, 1, 0);
            drive(sel, 0, 0, 1, 0);
        end
        for (int i = 0; i < 3; i++) drive(sel, 0, 0, 0, 0);
    endtask

    task automatic fill(input int v);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < L; c++) img[r][c] = v;
    endtask

    task automatic fill_grad();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < L; c++) img[r][c] = (r*37 + c*23 + 11) % 256;
    endtask

    task automatic fill_alt();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < L; c++) img[r][c] = ((r + c) % 2 == 1) ? 250 : 10;
    endtask

    always @(negedge clk) begin
        int e;
        chk("sync_a", int'({a_dv_out, a_hs_out, a_vs_out}), int'(sh_a[5]));
        for (int i = 5; i > 0; i--) sh_a[i] = sh_a[i-1];
        sh_a[0] = {a_dv, a_hs, a_vs};
        if (a_dv_out) begin
            if (qa.size() == 0) begin
                chk("dout_a_unexpected", int'(a_dout), -1);
            end else begin
                e = qa.pop_front();
                chk("dout_a", int'(a_dout), e);
            end
        end
    end

    always @(negedge clk) begin
        int e;
        chk("sync_b", int'({b_dv_out, b_hs_out, b_vs_out}), int'(sh_b[5]));
        for (int i = 5; i > 0; i--) sh_b[i] = sh_b[i-1];
        sh_b[0] = {b_dv, b_hs, b_vs};
        if (b_dv_out) begin
            if (qb.size() == 0) begin
                chk("dout_b_unexpected", int'(b_dout), -1);
            end else begin
                e = qb.pop_front();
                chk("dout_b", int'(b_dout), e);
            end
        end
    end

    initial begin
        for (int i = 0; i < 6; i++) begin
            sh_a[i] = 3'b000;
            sh_b[i] = 3'b000;
        end
        for (int s = 0; s < 2; s++) begin
            cfg_m[s] = 0; cfg_k[s] = 0; prev_vs[s] = 0; armed[s] = 0;
        end
        #1 rst = 1'b1;
        #2;
        chk("reset_dout_a", int'(a_dout), 0);
        chk("reset_dv_a", int'(a_dv_out), 0);
        chk("reset_vs_a", int'(a_vs_out), 0);
        chk("reset_dout_b", int'(b_dout), 0);
        #19 rst = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 0);

        // Flat 100, cross, k=4: interior outputs 100.
        a_mode = 2'd1; a_k = 4'd4; fill(100); send_frame(0, -1, -1);
        // Lone 200 on black, cross, k=4: centre 255, cross neighbours 0.
        fill(0); img[2][3] = 200; send_frame(0, -1, -1);
        // Centre 100 in a field of 80: full k=1 -> 140, cross k=1 -> 120.
        fill(80); img[2][3] = 100;
        a_mode = 2'd2; a_k = 4'd1; send_frame(0, -1, -1);
        a_mode = 2'd1; send_frame(0, -1, -1);
        // Checkerboard at max gain drives both clamp limits.
        fill_alt(); a_mode = 2'd2; a_k = 4'd15; send_frame(0, -1, -1);
        fill_grad(); a_mode = 2'd3; send_frame(0, -1, -1);
        a_mode = 2'd1; a_k = 4'd0; send_frame(0, -1, -1);
        // Mid-frame mode change only takes effect on the next frame.
        a_mode = 2'd1; a_k = 4'd6; send_frame(0, 3, -1);
        send_frame(0, -1, -1);
        a_bypass = 1'b1; send_frame(0, -1, -1);
        a_bypass = 1'b0;
        // Reset mid-line: bypass of centre until the next frame start reloads mode 1.
        a_mode = 2'd1; a_k = 4'd4; send_frame(0, -1, 2*L + 4);
        fill(0); img[2][3] = 200; send_frame(0, -1, -1);

        // Wide instance, full kernel, k=63: 1023 spike stays 1023, inverse hole gives 0.
        b_mode = 2'd2; b_k = 6'd63;
        for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 0);
        fill(0); img[2][3] = 1023; send_frame(1, -1, -1);
        fill(1023); img[2][3] = 0; send_frame(1, -1, -1);

        for (int i = 0; i < 10; i++) drive(1, 0, 0, 0, 0);
        chk("queue_a_drained", qa.size(), 0);
        chk("queue_b_drained", qb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
